pipelined_cla_adder: RTL and testbench

//   Parametrised, pipelined carry-lookahead adder/subtractor built from BLOCK-bit CLA slices.

---
 rtl/cla_pkg.sv | 23 ++
 rtl/cla_block.sv | 55 +++++
 rtl/pipelined_cla_adder.sv | 189 ++++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder.
//   stage_width  : bits resolved per pipeline stage (BLOCK * BLOCKS_PER_STAGE)
//   num_stages   : pipeline depth (WIDTH / stage_width), never below 1
//   params_legal : 1 when WIDTH is a positive multiple of the stage width
package cla_pkg;

   function automatic int stage_width(input int block, input int blocks_per_stage);
      // Clamped so an illegal configuration still elaborates far enough to report its error.
      return (block * blocks_per_stage < 1) ? 1 : block * blocks_per_stage;
   endfunction

   function automatic int num_stages(input int width, input int block, input int blocks_per_stage);
      int n;
      n = width / stage_width(block, blocks_per_stage);
      return (n < 1) ? 1 : n;
   endfunction

   function automatic bit params_legal(input int width, input int block, input int blocks_per_stage);
      if (block < 1 || blocks_per_stage < 1) return 1'b0;
      return (width >= block * blocks_per_stage) && (width % (block * blocks_per_stage) == 0);
   endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead slice.
// Ports:
//   a, b  in  BLOCK  operand bits of this slice (b already inverted for subtraction)
//   cin   in  1      carry into bit 0 of the slice
//   sum   out BLOCK  slice sum
//   cout  out 1      carry out of the slice
//   p, g  out 1      group propagate / group generate
module cla_block
   import cla_pkg::*;
#(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] sum,
   output logic             cout,
   output logic             p,
   output logic             g
);

   logic [BLOCK-1:0] bit_p;
   logic [BLOCK-1:0] bit_g;
   logic [BLOCK-1:0] carry;

   assign bit_p = a ^ b;
   assign bit_g = a & b;

   always_comb begin
      logic acc;
      // NOTE: every variable an always_comb writes gets a value before any loop or branch, so no latch is inferred.
      carry    = '0;
      acc      = 1'b0;
      carry[0] = cin;
      // Each carry is expanded from the slice inputs alone (g | p&g | ... | p..p&cin),
      // so synthesis sees a flat lookahead term per bit rather than a chain.
      for (int i = 1; i < BLOCK; i++) begin
         acc = cin;
         for (int j = 0; j < i; j++) acc = bit_g[j] | (bit_p[j] & acc);
         carry[i] = acc;
      end
   end

   always_comb begin
      logic grp_g;
      grp_g = 1'b0;
      for (int j = 0; j < BLOCK; j++) grp_g = bit_g[j] | (bit_p[j] & grp_g);
      g    = grp_g;
      p    = &bit_p;
      cout = grp_g | (&bit_p & cin);
   end

   assign sum = bit_p ^ carry;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Each stage resolves BLOCK*BLOCKS_PER_STAGE sum bits from the carry registered by
// the previous stage; unconsumed operand bits travel forward and finished sum bits
// are carried along so the whole word leaves together.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, cin, sub)
//   sub                  0: a+b+cin   1: a-b (cin ignored)
//   out_valid / out_ready result handshake (sum, cout[, ovf, zero])
//   cout                 carry out of bit WIDTH-1 (sub: 1 means a>=b unsigned)
// Build option: define CLA_FLAGS_EN to add the registered ovf and zero outputs.
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH            = 32,
   parameter int BLOCK            = 4,
   parameter int BLOCKS_PER_STAGE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CLA_FLAGS_EN
   ,output logic            ovf,
   output logic             zero
`endif
);

   localparam int NSTAGES = num_stages(WIDTH, BLOCK, BLOCKS_PER_STAGE);
   localparam int NBLK    = NSTAGES * BLOCKS_PER_STAGE;

   if (!params_legal(WIDTH, BLOCK, BLOCKS_PER_STAGE)) begin : g_param_check
      $error("pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK*BLOCKS_PER_STAGE");
   end

   // Index s of every *_q array is the state leaving stage s; *_d is what stage s loads.
   logic             valid_q [NSTAGES];
   logic [WIDTH-1:0] a_q     [NSTAGES];
   logic [WIDTH-1:0] b_q     [NSTAGES];
   logic             sub_q   [NSTAGES];
   logic             carry_q [NSTAGES];
   logic [WIDTH-1:0] sum_q   [NSTAGES];

   logic             valid_d [NSTAGES];
   logic [WIDTH-1:0] a_d     [NSTAGES];
   logic [WIDTH-1:0] b_d     [NSTAGES];
   logic             sub_d   [NSTAGES];
   logic             carry_d [NSTAGES];
   logic [WIDTH-1:0] sum_d   [NSTAGES];
   logic [WIDTH-1:0] b_eff   [NSTAGES];
   logic             st_cin  [NSTAGES];
   logic             ready   [NSTAGES+1];

   logic [BLOCK-1:0] blk_sum  [NBLK];
   logic             blk_cin  [NBLK];
   logic             blk_cout [NBLK];
   logic             blk_p    [NBLK];
   logic             blk_g    [NBLK];

   // Stage inputs: stage 0 takes the ports, later stages take the previous stage's registers.
   always_comb begin
      valid_d[0] = in_valid;
      a_d[0]     = a;
      b_d[0]     = b;
      sub_d[0]   = sub;
      st_cin[0]  = sub ? 1'b1 : cin;
      for (int s = 1; s < NSTAGES; s++) begin
         valid_d[s] = valid_q[s-1];
         a_d[s]     = a_q[s-1];
         b_d[s]     = b_q[s-1];
         sub_d[s]   = sub_q[s-1];
         st_cin[s]  = carry_q[s-1];
      end
      for (int s = 0; s < NSTAGES; s++) b_eff[s] = b_d[s] ^ {WIDTH{sub_d[s]}};
   end

   // Carry between slices of one stage ripples on the group P/G signals, which
   // depend only on the operands, so each slice's carry-in needs no slice sum.
   always_comb begin
      logic carry_run;
      carry_run = 1'b0;
      for (int k = 0; k < NBLK; k++) begin
         if (k % BLOCKS_PER_STAGE == 0) carry_run = st_cin[k / BLOCKS_PER_STAGE];
         blk_cin[k] = carry_run;
         carry_run  = blk_g[k] | (blk_p[k] & carry_run);
      end
   end

   for (genvar k = 0; k < NBLK; k++) begin : g_blk
      localparam int S = k / BLOCKS_PER_STAGE;
      cla_block #(.BLOCK(BLOCK)) u_cla_block (
         .a    (a_d[S][k*BLOCK +: BLOCK]),
         .b    (b_eff[S][k*BLOCK +: BLOCK]),
         .cin  (blk_cin[k]),
         .sum  (blk_sum[k]),
         .cout (blk_cout[k]),
         .p    (blk_p[k]),
         .g    (blk_g[k])
      );
   end

   // Backpressure chain: a stage advances when it is empty or its successor advances.
   always_comb begin
      ready[NSTAGES] = out_ready;
      for (int s = NSTAGES - 1; s >= 0; s--) ready[s] = !valid_q[s] || ready[s+1];
   end

   // Finished sum slices from earlier stages ride along; this stage drops its slice in.
   always_comb begin
      sum_d[0] = '0;
      for (int s = 1; s < NSTAGES; s++) sum_d[s] = sum_q[s-1];
      for (int k = 0; k < NBLK; k++) sum_d[k / BLOCKS_PER_STAGE][k*BLOCK +: BLOCK] = blk_sum[k];
      for (int s = 0; s < NSTAGES; s++)
         carry_d[s] = blk_cout[s*BLOCKS_PER_STAGE + BLOCKS_PER_STAGE - 1];
   end

`ifdef CLA_FLAGS_EN
   logic zero_q [NSTAGES];
   logic zero_d [NSTAGES];
   logic ovf_q;
   logic ovf_d;

   always_comb begin
      zero_d[0] = 1'b1;
      for (int s = 1; s < NSTAGES; s++) zero_d[s] = zero_q[s-1];
      for (int k = 0; k < NBLK; k++)
         zero_d[k / BLOCKS_PER_STAGE] = zero_d[k / BLOCKS_PER_STAGE] & ~|blk_sum[k];
      // Carry into the MSB is recovered from the MSB sum bit: c = a ^ b ^ s.
      ovf_d = a_d[NSTAGES-1][WIDTH-1] ^ b_eff[NSTAGES-1][WIDTH-1]
            ^ blk_sum[NBLK-1][BLOCK-1] ^ blk_cout[NBLK-1];
   end
`endif

   always_ff @(posedge clk) begin
      // NOTE: state is updated with <= so each stage loads its predecessor's pre-edge value.
      if (rst) begin
         // NOTE: datapath registers are cleared too, so sum/cout (and flags) read 0 after reset.
         for (int s = 0; s < NSTAGES; s++) begin
            valid_q[s] <= 1'b0;
            a_q[s]     <= '0;
            b_q[s]     <= '0;
            sub_q[s]   <= 1'b0;
            carry_q[s] <= 1'b0;
            sum_q[s]   <= '0;
`ifdef CLA_FLAGS_EN
            zero_q[s]  <= 1'b0;
`endif
         end
`ifdef CLA_FLAGS_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         for (int s = 0; s < NSTAGES; s++) begin
            if (ready[s]) begin
               valid_q[s] <= valid_d[s];
               a_q[s]     <= a_d[s];
               b_q[s]     <= b_d[s];
               sub_q[s]   <= sub_d[s];
               carry_q[s] <= carry_d[s];
               sum_q[s]   <= sum_d[s];
`ifdef CLA_FLAGS_EN
               zero_q[s]  <= zero_d[s];
`endif
            end
         end
`ifdef CLA_FLAGS_EN
         if (ready[NSTAGES-1]) ovf_q <= ovf_d;
`endif
      end
   end

   assign in_ready  = ready[0];
   assign out_valid = valid_q[NSTAGES-1];
   assign sum       = sum_q[NSTAGES-1];
   assign cout      = carry_q[NSTAGES-1];
`ifdef CLA_FLAGS_EN
   assign ovf       = ovf_q;
   assign zero      = zero_q[NSTAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: a 32-bit instance (4 stages) checked
// against an arithmetic reference model every cycle, plus a 16-bit single-stage instance.
module tb_pipelined_cla_adder;

   localparam int W   = 32;
   localparam int NST = 4;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
   } res_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
   logic [W-1:0]  a, b, sum;
   logic          r16_in_valid, r16_in_ready, r16_out_valid, r16_cout;
   logic [15:0]   r16_a, r16_b, r16_sum;
`ifdef CLA_FLAGS_EN
   logic          ovf, zero, r16_ovf, r16_zero;
`endif

   int errors = 0;
   int checks = 0;
   int n_out  = 0;
   res_t exp_q[$];
   logic [W-1:0] cap_sum;
   logic         cap_cout;
`ifdef CLA_FLAGS_EN
   logic         cap_ovf, cap_zero;
`endif

   always #5 clk = ~clk;

   pipelined_cla_adder #(.WIDTH(W), .BLOCK(4), .BLOCKS_PER_STAGE(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef CLA_FLAGS_EN
      , .ovf(ovf), .zero(zero)
`endif
   );

   pipelined_cla_adder #(.WIDTH(16), .BLOCK(4), .BLOCKS_PER_STAGE(4)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(r16_in_valid), .in_ready(r16_in_ready),
      .a(r16_a), .b(r16_b), .cin(1'b0), .sub(1'b0),
      .out_valid(r16_out_valid), .out_ready(1'b1), .sum(r16_sum), .cout(r16_cout)
`ifdef CLA_FLAGS_EN
      , .ovf(r16_ovf), .zero(r16_zero)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: unsigned/signed integer arithmetic, not carry logic.
   function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mcin, input logic msub);
      res_t   r;
      longint ua, ub, sa, sb, tot, sres;
      ua = longint'(ma);
      ub = longint'(mb);
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      if (msub) begin
         tot    = ua - ub;
         r.cout = (ua >= ub);
         sres   = sa - sb;
      end else begin
         tot    = ua + ub + longint'(mcin);
         r.cout = (tot >= 64'sh1_0000_0000);
         sres   = sa + sb + longint'(mcin);
      end
      r.sum  = tot[W-1:0];
      r.ovf  = (sres > 64'sh7FFF_FFFF) || (sres < -64'sh8000_0000);
      r.zero = (r.sum == '0);
      return r;
   endfunction

   // Compare process: outputs and input handshakes are sampled on the falling edge.
   logic         stall_prev = 1'b0;
   logic [W-1:0] held_sum;
   logic         held_cout;
   always @(negedge clk) begin
      res_t r;
      if (rst) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_sum", sum, held_sum);
            check("hold_cout", cout, held_cout);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", out_valid, 1'b0);
            end else begin
               r = exp_q.pop_front();
               check("model_sum", sum, r.sum);
               check("model_cout", cout, r.cout);
`ifdef CLA_FLAGS_EN
               check("model_ovf", ovf, r.ovf);
               check("model_zero", zero, r.zero);
`endif
               n_out++;
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
         stall_prev = out_valid && !out_ready;
         held_sum   = sum;
         held_cout  = cout;
      end
   end

   // One isolated operation with out_ready=1; checks accept, latency and single-cycle pulse.
   task automatic single_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tcin, input logic tsub, input string tag);
      int lat;
      @(posedge clk); #1;
      in_valid = 1'b1; a = ta; b = tb; cin = tcin; sub = tsub;
      @(negedge clk);
      check({tag, "_accept"}, in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = n;
            break;
         end
      end
      check({tag, "_latency"}, lat, NST);
      cap_sum  = sum;
      cap_cout = cout;
`ifdef CLA_FLAGS_EN
      cap_ovf  = ovf;
      cap_zero = zero;
`endif
      @(negedge clk);
      check({tag, "_pulse"}, out_valid, 1'b0);
   endtask

   task automatic rand_op();
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 7))
         0: b = ~a;
         1: b = a;
         2: a = 32'hFFFF_FFFF;
         3: b = 32'h8000_0000;
         default: ;
      endcase
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_drain(input string tag);
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc, sent, base, guard;
      logic hs;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      r16_in_valid = 1'b0; r16_a = '0; r16_b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_sum", sum, 32'h0);
      check("reset_cout", cout, 1'b0);
      check("reset_in_ready", in_ready, 1'b1);
`ifdef CLA_FLAGS_EN
      check("reset_ovf", ovf, 1'b0);
      check("reset_zero", zero, 1'b0);
`endif

      // Basic add
      single_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, "add_wrap");
      check("add_wrap_sum", cap_sum, 32'h0);
      check("add_wrap_cout", cap_cout, 1'b1);
`ifdef CLA_FLAGS_EN
      check("add_wrap_ovf", cap_ovf, 1'b0);
      check("add_wrap_zero", cap_zero, 1'b1);
`endif

      // Subtract, cin ignored
      single_op(32'd5, 32'd7, 1'b0, 1'b1, "sub_neg");
      check("sub_neg_sum", cap_sum, 32'hFFFF_FFFE);
      check("sub_neg_cout", cap_cout, 1'b0);
      single_op(32'd7, 32'd5, 1'b0, 1'b1, "sub_pos");
      check("sub_pos_sum", cap_sum, 32'h2);
      check("sub_pos_cout", cap_cout, 1'b1);
      single_op(32'd7, 32'd5, 1'b1, 1'b1, "sub_cin");
      check("sub_cin_sum", cap_sum, 32'h2);
      check("sub_cin_cout", cap_cout, 1'b1);
      single_op(32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, "add_cin");
      check("add_cin_sum", cap_sum, 32'h0000_0101);

`ifdef CLA_FLAGS_EN
      single_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, "flag_ovf");
      check("flag_ovf_sum", cap_sum, 32'h8000_0000);
      check("flag_ovf_ovf", cap_ovf, 1'b1);
      check("flag_ovf_zero", cap_zero, 1'b0);
      single_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "flag_min");
      check("flag_min_sum", cap_sum, 32'h0);
      check("flag_min_cout", cap_cout, 1'b1);
      check("flag_min_ovf", cap_ovf, 1'b1);
      check("flag_min_zero", cap_zero, 1'b1);
`endif

      // Streaming: 100 back-to-back operations
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         rand_op();
         @(negedge clk);
         check("stream_in_ready", in_ready, 1'b1);
      end
      @(posedge clk); #1 in_valid = 1'b0;
      wait_drain("stream");

      // Backpressure: out_ready held low for 10 cycles
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
      a = 32'h1000_0001; b = 32'h2000_0002;
      base = n_out; acc = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk); #1;
         if (hs) begin
            acc++;
            a = 32'h1000_0001 + 32'(acc);
            b = 32'h2000_0002 + 32'(acc << 4);
         end
         if (c == 9) in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_accepts", acc, 4);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_head_sum", sum, 32'h3000_0003);
      @(posedge clk); #1 out_ready = 1'b1;
      wait_drain("bp");
      check("bp_results", n_out - base, 4);

      // Random backpressure with random out_ready
      sent = 0; guard = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      rand_op();
      while (sent < 60 && guard < 2000) begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk); #1;
         out_ready = ($urandom_range(0, 3) != 0);
         if (hs) begin
            sent++;
            if (sent < 60) rand_op();
            else in_valid = 1'b0;
         end
         guard++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("rbp_sent", sent, 60);
      wait_drain("rbp");

      // Reset with three operations in flight
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; a = 32'h0100_0000 * 32'(i + 1); b = 32'h55; cin = 1'b0; sub = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("flush_out_valid", out_valid, 1'b0);
      check("flush_sum", sum, 32'h0);
      check("flush_cout", cout, 1'b0);
      check("flush_in_ready", in_ready, 1'b1);
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         check("flush_no_output", out_valid, 1'b0);
      end

      // Single-stage configuration: latency 1
      @(posedge clk); #1;
      r16_in_valid = 1'b1; r16_a = 16'hFFFF; r16_b = 16'h0001;
      @(negedge clk);
      check("w16_accept", r16_in_ready, 1'b1);
      @(posedge clk); #1 r16_in_valid = 1'b0;
      @(negedge clk);
      check("w16_out_valid", r16_out_valid, 1'b1);
      check("w16_sum", r16_sum, 16'h0);
      check("w16_cout", r16_cout, 1'b1);
`ifdef CLA_FLAGS_EN
      check("w16_ovf", r16_ovf, 1'b0);
      check("w16_zero", r16_zero, 1'b1);
`endif
      @(negedge clk);
      check("w16_pulse", r16_out_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
